// File: rtl/stall_mem_responder_pkg.sv
// stall_mem_responder_pkg: shared widths, defaults and FSM state type for the stalling memory responder
package stall_mem_responder_pkg;
    localparam int WORD_W         = 16;
    localparam int CNT_W          = 4;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_DEPTH_LOG2 = 8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/stall_mem_responder_if.sv
// stall_mem_responder_if: data-memory request/response bundle between processor and responder
interface stall_mem_responder_if;
    import stall_mem_responder_pkg::*;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data_out;
    logic              rd;
    logic              wr;
    logic              done;
    logic              stall;
    logic              err;
    modport master (output data_in, addr, rd, wr, input data_out, done, stall, err);
    modport slave  (input data_in, addr, rd, wr, output data_out, done, stall, err);
endinterface

// File: rtl/stall_mem_responder_array.sv
// stall_mem_array: single-port word storage with registered read, never cleared by reset
module stall_mem_array
    import stall_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);
    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];
    // write-through storage; the read register samples the addressed word every edge (read-first)
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/stall_mem_responder.sv
// stall_mem_responder: accepts one read/write at a time and completes it after LATENCY cycles
module stall_mem_responder
    import stall_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    stall_mem_responder_if.slave  bus
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [WORD_W-1:0]     rdata;
    logic                  req, bad, stall, accept;
    logic                  unused_hi;
    assign req       = bus.rd | bus.wr;
    assign bad       = (bus.rd & bus.wr) | (req & bus.addr[0]);
    assign stall     = state_q == BUSY;
    assign accept    = !stall && req && !bad;
    assign unused_hi = ^bus.addr[WORD_W-1:DEPTH_LOG2+1];
    // the array is addressed by the live request on the accepting edge, otherwise by the held index
    stall_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (accept && bus.wr && !rst),
        .idx   (accept ? bus.addr[DEPTH_LOG2:1] : idx_q),
        .wdata (bus.data_in),
        .rdata (rdata)
    );
    // next state: count down while busy; from IDLE or RESP accept a new request or fall back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = !stall && bad;
        if (stall) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CNT_W'(1) ? RESP : BUSY;
        end else begin
            state_d = IDLE;
            if (accept) begin
                state_d = LATENCY == 1 ? RESP : BUSY;
                cnt_d   = LOAD;
                idx_d   = bus.addr[DEPTH_LOG2:1];
                wr_d    = bus.wr;
            end
        end
    end
    // state register with synchronous reset; storage is deliberately left untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end
    assign bus.stall    = stall;
    assign bus.err      = err_q;
    assign bus.done     = (state_q == RESP) | err_q;
    assign bus.data_out = (state_q == RESP && !wr_q) ? rdata : '0;
endmodule
